sum_bcd_scan_display: RTL and testbench

- Downstream consumer of the N-bit adder sum.
- Converts a registered binary sum to BCD with a sequential double-dabble engine, then drives a time-multiplexed multi-digit 7-segment display.
- Replaces the single-digit hex decoder on boards with shared segment lines and per-digit enables, so sums above 9 display in decimal.

---
 rtl/sum_bcd_scan_display.sv | 186 ++++++++++++++++++
 tb/tb_sum_bcd_scan_display.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_scan_display.sv
// Binary sum -> BCD (sequential double-dabble) feeding a time-multiplexed 7-segment scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module sum_bcd_scan_display #(
  parameter int W              = 4,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int ACTIVE_LOW_SEG = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [W-1:0]          i_sum,
  input  logic                  i_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_dig,
  output logic [6:0]            o_seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_RST  = (ACTIVE_LOW_SEG != 0) ? ~SEG_ZERO : SEG_ZERO;

  // Handshake: i_valid is a single-cycle strobe, taken only when the converter is
  // not busy (IDLE, or the COMMIT cycle for back-to-back); otherwise it is dropped.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic               accept;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  dig_q, dig_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         cur_nib;
  logic [6:0]         seg_raw;
  logic               pre_wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Add-3 correction applied to every scratch nibble before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    accept    = i_valid && ((state_q == IDLE) || (state_q == COMMIT));
    case (state_q)
      CONV: begin
        {scratch_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shift_d   = i_sum;
      scratch_d = '0;
      cnt_d     = CNT_W'(W);
      state_d   = CONV;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  // Scanner: free-running, independent of the converter.
  always_comb begin
    pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
    idx_d    = idx_q;
    if (pre_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    cur_nib  = 4'd0;
    dig_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_d[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) cur_nib = bcd_q[i*4 +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              lz_acc;
  logic              cur_blank;

  // A digit is blank when it and every digit above it are zero; units never blank.
  always_comb begin
    blank     = '0;
    lz_acc    = 1'b0;
    cur_blank = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_acc   = lz_acc | (bcd_q[i*4 +: 4] != 4'd0);
      blank[i] = ~lz_acc;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_blank = blank[i];
    end
    seg_raw = cur_blank ? 7'h00 : seg_decode(cur_nib);
  end
`else
  always_comb begin
    seg_raw = seg_decode(cur_nib);
  end
`endif

  always_comb begin
    seg_d = (ACTIVE_LOW_SEG != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q <= '0;
      idx_q <= '0;
      dig_q <= DIGITS'(1);
      seg_q <= SEG_RST;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end

  assign o_busy = (state_q == CONV);
  assign o_done = done_q;
  assign o_bcd  = bcd_q;
  assign o_dig  = dig_q;
  assign o_seg  = seg_q;

endmodule

// File: tb/tb_sum_bcd_scan_display.sv
// Directed bench for sum_bcd_scan_display: a table of hand-computed vectors plus
// sequences for scanning, back-to-back requests, dropped requests and reset abort.
module tb_sum_bcd_scan_display;

  localparam int W        = 4;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] sum = '0;

  logic         busy, done, busy_n, done_n;
  logic [7:0]   bcd, bcd_n;
  logic [1:0]   dig, dig_n;
  logic [6:0]   seg, seg_n;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] sum;
    logic [7:0] bcd;
    logic [6:0] seg0;
    logic [6:0] seg1;
  } vec_t;
  vec_t vecs[16];

  sum_bcd_scan_display #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW_SEG(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_valid(valid),
    .o_busy(busy), .o_done(done), .o_bcd(bcd), .o_dig(dig), .o_seg(seg)
  );

  sum_bcd_scan_display #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW_SEG(1)) u_dut_n (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_valid(valid),
    .o_busy(busy_n), .o_done(done_n), .o_bcd(bcd_n), .o_dig(dig_n), .o_seg(seg_n)
  );

  // Clock / timeout
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] s);
    sum   = s;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 10 && !done; n++) tick();
  endtask

  // Visit digit 0 then digit 1 and compare both segment polarities.
  task automatic check_digits(input string name, input logic [6:0] e0, input logic [6:0] e1);
    logic [1:0] pat;
    logic [6:0] e;
    logic       found;
    tick();
    for (int d = 0; d < 2; d++) begin
      pat   = (d == 0) ? 2'b01 : 2'b10;
      e     = (d == 0) ? e0 : e1;
      found = 1'b0;
      for (int n = 0; n < 3 * SCAN_DIV && !found; n++) begin
        if (dig == pat) found = 1'b1;
        else tick();
      end
      check($sformatf("%s dig%0d reached", name, d), found, 1);
      if (found) begin
        check($sformatf("%s seg%0d", name, d), seg, e);
        check($sformatf("%s seg_n%0d", name, d), seg_n, e ^ 7'h7F);
        check($sformatf("%s dig_n%0d", name, d), dig_n, pat);
      end
    end
  endtask

  initial begin
    int last_done;
    int kc;
    int done_cnt;
    int done_cycle;
    logic [7:0] done_bcd;
    logic [6:0] e1;

    vecs[0]  = '{4'd0,  8'h00, 7'h3F, 7'h3F};
    vecs[1]  = '{4'd1,  8'h01, 7'h06, 7'h3F};
    vecs[2]  = '{4'd2,  8'h02, 7'h5B, 7'h3F};
    vecs[3]  = '{4'd3,  8'h03, 7'h4F, 7'h3F};
    vecs[4]  = '{4'd4,  8'h04, 7'h66, 7'h3F};
    vecs[5]  = '{4'd5,  8'h05, 7'h6D, 7'h3F};
    vecs[6]  = '{4'd6,  8'h06, 7'h7D, 7'h3F};
    vecs[7]  = '{4'd7,  8'h07, 7'h07, 7'h3F};
    vecs[8]  = '{4'd8,  8'h08, 7'h7F, 7'h3F};
    vecs[9]  = '{4'd9,  8'h09, 7'h6F, 7'h3F};
    vecs[10] = '{4'd10, 8'h10, 7'h3F, 7'h06};
    vecs[11] = '{4'd11, 8'h11, 7'h06, 7'h06};
    vecs[12] = '{4'd12, 8'h12, 7'h5B, 7'h06};
    vecs[13] = '{4'd13, 8'h13, 7'h4F, 7'h06};
    vecs[14] = '{4'd14, 8'h14, 7'h66, 7'h06};
    vecs[15] = '{4'd15, 8'h15, 7'h6D, 7'h06};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bcd", bcd, 8'h00);
    check("rst dig", dig, 2'b01);
    check("rst seg", seg, 7'h3F);
    check("rst seg_n", seg_n, 7'h40);

    // Idle scanning: index moves every SCAN_DIV cycles, outputs one cycle later
    repeat (4) tick();
    check("scan e4 dig", dig, 2'b01);
    tick();
    check("scan e5 dig", dig, 2'b10);
    check("scan e5 seg", seg, 7'h3F);
    repeat (3) tick();
    check("scan e8 dig", dig, 2'b10);
    tick();
    check("scan e9 dig", dig, 2'b01);
    check("scan e9 seg", seg, 7'h3F);

    // Single conversion of 15 with latency checks
    send(4'd15);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("conv15 busy c%0d", n + 1), busy, 1);
      check($sformatf("conv15 done c%0d", n + 1), done, 0);
      tick();
    end
    check("conv15 commit busy", busy, 0);
    check("conv15 commit done", done, 0);
    tick();
    check("conv15 done", done, 1);
    check("conv15 bcd", bcd, 8'h15);
    check("conv15 busy after", busy, 0);
    tick();
    check("conv15 done width", done, 0);
    check_digits("conv15", 7'h6D, 7'h06);

    // Exhaustive back-to-back: next request rides the commit edge
    exp_q.push_back(vecs[0].bcd);
    send(vecs[0].sum);
    last_done = 0;
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < 10 && busy; n++) tick();
      if (i < 15) begin
        sum   = vecs[i + 1].sum;
        valid = 1'b1;
        exp_q.push_back(vecs[i + 1].bcd);
      end
      tick();
      valid = 1'b0;
      check($sformatf("b2b done %0d", i), done, 1);
      if (exp_q.size() > 0) check($sformatf("b2b bcd %0d", i), bcd, exp_q.pop_front());
      if (i > 0) check($sformatf("b2b gap %0d", i), cycle - last_done, 5);
      last_done = cycle;
    end
    check("b2b queue empty", exp_q.size(), 0);

    // Table: each value converted alone, then both digits inspected
    for (int i = 0; i < 16; i++) begin
      tick();
      send(vecs[i].sum);
      wait_done();
      check($sformatf("tbl done %0d", i), done, 1);
      check($sformatf("tbl bcd %0d", i), bcd, vecs[i].bcd);
      e1 = (LZB && vecs[i].bcd[7:4] == 4'd0) ? 7'h00 : vecs[i].seg1;
      check_digits($sformatf("tbl %0d", i), vecs[i].seg0, e1);
    end

    // Request while busy is dropped
    tick();
    send(4'd9);
    kc = cycle;
    tick();
    sum   = 4'd3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    done_cnt   = 0;
    done_cycle = 0;
    done_bcd   = '0;
    for (int n = 0; n < 12; n++) begin
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
        done_bcd   = bcd;
      end
      tick();
    end
    check("drop done count", done_cnt, 1);
    check("drop bcd", done_bcd, 8'h09);
    check("drop latency", done_cycle - kc, 5);
    check("drop bcd final", bcd, 8'h09);

    // Reset mid-conversion aborts
    send(4'd12);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort bcd", bcd, 8'h00);
    check("abort dig", dig, 2'b01);
    done_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    check("abort bcd held", bcd, 8'h00);

    // Leading digit handling for a single-digit value, both polarities
    send(4'd7);
    wait_done();
    check("seven bcd", bcd, 8'h07);
    check_digits("seven", 7'h07, LZB ? 7'h00 : 7'h3F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
